// File: rtl/vec_switch.sv
// vec_switch: CORE_COUNT x CORE_COUNT mailbox switch carrying whole vectors between cores
module vec_switch #(
    parameter int CORE_COUNT = 4,
    parameter int LANES = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int ADDR_SIZE = $clog2(CORE_COUNT)
) (
    input  logic clock,
    input  logic reset,
    input  logic [CORE_COUNT-1:0] send_ready,
    input  logic [CORE_COUNT*ADDR_SIZE-1:0] send_core_idx,
    input  logic [CORE_COUNT*LANES*DATA_WIDTH-1:0] send_data,
    output logic [CORE_COUNT-1:0] send_ok,
    input  logic [CORE_COUNT-1:0] recv_request,
    input  logic [CORE_COUNT*ADDR_SIZE-1:0] recv_core_idx,
    output logic [CORE_COUNT-1:0] recv_ready,
    output logic [CORE_COUNT*LANES*DATA_WIDTH-1:0] recv_data,
    output logic [CORE_COUNT*CORE_COUNT-1:0] mbox_full,
    output logic [CORE_COUNT*CORE_COUNT-1:0] mbox_empty
);
    localparam int VW = LANES * DATA_WIDTH;
    localparam int NM = CORE_COUNT * CORE_COUNT;
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CORE_COUNT-1:0] send_acc, recv_acc;
    logic [NM-1:0] push, pop;
    logic [VW-1:0] head [NM];
    logic [VW-1:0] rnext [CORE_COUNT];

    // mailbox m connects source m/CORE_COUNT to destination m%CORE_COUNT
    for (genvar m = 0; m < NM; m++) begin : g_mbox
        localparam int S = m / CORE_COUNT;
        localparam int D = m % CORE_COUNT;
        logic [VW-1:0] mem [DEPTH];
        logic [PW-1:0] wptr, rptr;
        logic [CW-1:0] cnt;
        assign push[m] = send_acc[S] && send_core_idx[S*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(D);
        assign pop[m] = recv_acc[D] && recv_core_idx[D*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(S);
        assign head[m] = mem[rptr];
        assign mbox_full[m] = cnt == CW'(DEPTH);
        assign mbox_empty[m] = cnt == '0;
        // payload storage; left unreset because the count gates every read
        always_ff @(posedge clock) begin
            if (push[m]) mem[wptr] <= send_data[S*VW +: VW];
        end
        // pointers wrap modulo DEPTH; count tracks occupancy
        always_ff @(posedge clock) begin
            if (reset) begin
                wptr <= '0;
                rptr <= '0;
                cnt <= '0;
            end else begin
                if (push[m]) wptr <= wptr == PW'(DEPTH - 1) ? '0 : wptr + 1'b1;
                if (pop[m]) rptr <= rptr == PW'(DEPTH - 1) ? '0 : rptr + 1'b1;
                cnt <= cnt + CW'(push[m]) - CW'(pop[m]);
            end
        end
    end

    // per-core accept decisions against start-of-cycle full/empty status
    for (genvar i = 0; i < CORE_COUNT; i++) begin : g_core
        logic [ADDR_SIZE-1:0] dst, src;
        logic [CORE_COUNT-1:0] full_row, empty_col;
        logic [VW-1:0] head_col [CORE_COUNT];
        assign dst = send_core_idx[i*ADDR_SIZE +: ADDR_SIZE];
        assign src = recv_core_idx[i*ADDR_SIZE +: ADDR_SIZE];
        assign full_row = mbox_full[i*CORE_COUNT +: CORE_COUNT];
        for (genvar k = 0; k < CORE_COUNT; k++) begin : g_col
            assign empty_col[k] = mbox_empty[k*CORE_COUNT + i];
            assign head_col[k] = head[k*CORE_COUNT + i];
        end
        assign send_acc[i] = send_ready[i] && !send_ok[i] && int'(dst) < CORE_COUNT && !full_row[dst];
        assign recv_acc[i] = recv_request[i] && !recv_ready[i] && int'(src) < CORE_COUNT && !empty_col[src];
        assign rnext[i] = head_col[src];
    end

    // handshake pulses and received vectors, held until the next receive
    always_ff @(posedge clock) begin
        send_ok <= reset ? '0 : send_acc;
        recv_ready <= reset ? '0 : recv_acc;
        for (int j = 0; j < CORE_COUNT; j++) begin
            if (reset) recv_data[j*VW +: VW] <= '0;
            else if (recv_acc[j]) recv_data[j*VW +: VW] <= rnext[j];
        end
    end
endmodule

// File: tb/tb_vec_switch.sv
// tb_vec_switch: directed and random checks of vec_switch against a queue-based mailbox model
module tb_vec_switch;
    localparam int C = 4;
    localparam int VW = 16 * 32;
    localparam int D = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [C-1:0] send_ready = '0, recv_request = '0;
    logic [1:0] sidx [C], ridx [C];
    logic [VW-1:0] sdat [C];
    logic [2*C-1:0] send_core_idx, recv_core_idx;
    logic [C*VW-1:0] send_data, recv_data;
    logic [C-1:0] send_ok, recv_ready;
    logic [C*C-1:0] mbox_full, mbox_empty;

    logic [VW-1:0] q [C*C][$];
    logic [C-1:0] m_sok = '0, m_rr = '0;
    logic [VW-1:0] m_rd [C];
    int tests = 0, fails = 0;
    logic [VW-1:0] va, vb, vc, vx, vy, fv;
    logic [VW-1:0] vv [C];

    vec_switch dut (
        .clock(clock), .reset(reset),
        .send_ready(send_ready), .send_core_idx(send_core_idx), .send_data(send_data),
        .send_ok(send_ok),
        .recv_request(recv_request), .recv_core_idx(recv_core_idx),
        .recv_ready(recv_ready), .recv_data(recv_data),
        .mbox_full(mbox_full), .mbox_empty(mbox_empty)
    );

    for (genvar g = 0; g < C; g++) begin : g_pack
        assign send_core_idx[g*2 +: 2] = sidx[g];
        assign recv_core_idx[g*2 +: 2] = ridx[g];
        assign send_data[g*VW +: VW] = sdat[g];
    end

    always #5 clock = ~clock;

    function automatic logic [31:0] fbits(int n);
        int e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: model decides from start-of-cycle occupancy, then DUT outputs are compared
    task automatic step();
        logic [C-1:0] as, ar;
        logic [C*C-1:0] ef, ee;
        for (int i = 0; i < C; i++) begin
            as[i] = send_ready[i] && !m_sok[i] && q[i*C + int'(sidx[i])].size() < D;
            ar[i] = recv_request[i] && !m_rr[i] && q[int'(ridx[i])*C + i].size() > 0;
        end
        if (reset) begin
            for (int m = 0; m < C*C; m++) q[m].delete();
            for (int j = 0; j < C; j++) m_rd[j] = '0;
            m_sok = '0;
            m_rr = '0;
        end else begin
            for (int j = 0; j < C; j++) if (ar[j]) m_rd[j] = q[int'(ridx[j])*C + j].pop_front();
            for (int i = 0; i < C; i++) if (as[i]) q[i*C + int'(sidx[i])].push_back(sdat[i]);
            m_sok = as;
            m_rr = ar;
        end
        @(posedge clock);
        #1;
        for (int m = 0; m < C*C; m++) begin
            ef[m] = q[m].size() == D;
            ee[m] = q[m].size() == 0;
        end
        chk("model_send_ok", VW'(send_ok), VW'(m_sok));
        chk("model_recv_ready", VW'(recv_ready), VW'(m_rr));
        for (int j = 0; j < C; j++) chk($sformatf("model_recv_data%0d", j), recv_data[j*VW +: VW], m_rd[j]);
        chk("model_full", VW'(mbox_full), VW'(ef));
        chk("model_empty", VW'(mbox_empty), VW'(ee));
    endtask

    task automatic send_one(input int i, input int d, input logic [VW-1:0] v);
        int n = 0;
        send_ready[i] = 1'b1;
        sidx[i] = 2'(d);
        sdat[i] = v;
        do begin step(); n++; end while (!m_sok[i] && n < 8);
        chk("send_one_ack", VW'(send_ok[i]), VW'(1));
        send_ready[i] = 1'b0;
    endtask

    task automatic recv_one(input int j, input int s, input logic [VW-1:0] v);
        int n = 0;
        recv_request[j] = 1'b1;
        ridx[j] = 2'(s);
        do begin step(); n++; end while (!m_rr[j] && n < 8);
        chk("recv_one_ready", VW'(recv_ready[j]), VW'(1));
        chk("recv_one_data", recv_data[j*VW +: VW], v);
        recv_request[j] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < C; i++) begin
            sidx[i] = '0;
            ridx[i] = '0;
            sdat[i] = '0;
            m_rd[i] = '0;
        end
        // reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_send_ok", VW'(send_ok), VW'(0));
        chk("rst_recv_ready", VW'(recv_ready), VW'(0));
        chk("rst_recv_data", recv_data[VW-1:0] | recv_data[2*VW-1:VW] | recv_data[3*VW-1:2*VW] | recv_data[4*VW-1:3*VW], '0);
        chk("rst_empty", VW'(mbox_empty), VW'(16'hffff));
        chk("rst_full", VW'(mbox_full), VW'(0));
        // single transfer 0 -> 2 of lanes 1.0 .. 16.0
        for (int k = 0; k < 16; k++) fv[k*32 +: 32] = fbits(k + 1);
        chk("float_lane0", VW'(fv[31:0]), VW'(32'h3f80_0000));
        send_ready[0] = 1'b1;
        sidx[0] = 2'd2;
        sdat[0] = fv;
        step();
        chk("single_ack", VW'(send_ok[0]), VW'(1));
        send_ready[0] = 1'b0;
        step();
        chk("single_ack_pulse", VW'(send_ok[0]), VW'(0));
        chk("single_not_empty", VW'(mbox_empty[2]), VW'(0));
        recv_request[2] = 1'b1;
        ridx[2] = 2'd0;
        step();
        chk("single_rr", VW'(recv_ready[2]), VW'(1));
        chk("single_data", recv_data[2*VW +: VW], fv);
        recv_request[2] = 1'b0;
        step();
        chk("single_rr_pulse", VW'(recv_ready[2]), VW'(0));
        chk("single_empty", VW'(mbox_empty[2]), VW'(1));
        chk("single_data_hold", recv_data[2*VW +: VW], fv);
        // full mailbox 1 -> 3
        va = rvec();
        vb = rvec();
        vc = rvec();
        send_one(1, 3, va);
        send_one(1, 3, vb);
        send_ready[1] = 1'b1;
        sdat[1] = vc;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("full_stall", VW'(send_ok[1]), VW'(0));
        end
        chk("full_flag", VW'(mbox_full[7]), VW'(1));
        recv_request[3] = 1'b1;
        ridx[3] = 2'd1;
        step();
        chk("full_pop_rr", VW'(recv_ready[3]), VW'(1));
        chk("full_pop_a", recv_data[3*VW +: VW], va);
        chk("full_no_bypass", VW'(send_ok[1]), VW'(0));
        recv_request[3] = 1'b0;
        step();
        chk("full_c_ack", VW'(send_ok[1]), VW'(1));
        send_ready[1] = 1'b0;
        recv_one(3, 1, vb);
        recv_one(3, 1, vc);
        // empty mailbox: request and send in the same cycle
        recv_request[2] = 1'b1;
        ridx[2] = 2'd0;
        send_ready[0] = 1'b1;
        sidx[0] = 2'd2;
        sdat[0] = va;
        step();
        chk("empty_send_ack", VW'(send_ok[0]), VW'(1));
        chk("empty_no_rr", VW'(recv_ready[2]), VW'(0));
        send_ready[0] = 1'b0;
        step();
        chk("empty_rr", VW'(recv_ready[2]), VW'(1));
        chk("empty_data", recv_data[2*VW +: VW], va);
        recv_request[2] = 1'b0;
        step();
        // all cores send to core 0 at once
        for (int i = 0; i < C; i++) begin
            vv[i] = rvec();
            sdat[i] = vv[i];
            sidx[i] = 2'd0;
        end
        send_ready = 4'hf;
        step();
        chk("conc_ack", VW'(send_ok), VW'(4'hf));
        send_ready = '0;
        recv_one(0, 3, vv[3]);
        recv_one(0, 1, vv[1]);
        recv_one(0, 0, vv[0]);
        recv_one(0, 2, vv[2]);
        // reset while mailbox 0 -> 1 is full
        vx = rvec();
        vy = rvec();
        send_one(0, 1, vx);
        send_one(0, 1, vy);
        step();
        chk("rstmid_full", VW'(mbox_full[1]), VW'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid_empty", VW'(mbox_empty[1]), VW'(1));
        recv_request[1] = 1'b1;
        ridx[1] = 2'd0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("rstmid_stall", VW'(recv_ready[1]), VW'(0));
        end
        recv_request[1] = 1'b0;
        // random traffic with senders holding requests until acknowledged
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset = $urandom_range(0, 99) == 0;
            for (int i = 0; i < C; i++) begin
                if (send_ready[i] && m_sok[i]) send_ready[i] = 1'b0;
                else if (!send_ready[i] && $urandom_range(0, 1) == 1) begin
                    send_ready[i] = 1'b1;
                    sidx[i] = 2'($urandom_range(0, 3));
                    sdat[i] = rvec();
                end
                recv_request[i] = 1'($urandom_range(0, 1));
                ridx[i] = 2'($urandom_range(0, 3));
            end
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vec_switch.md
# vec_switch

Inter-core switch that connects the switch ports of `CORE_COUNT` vector cores, replacing the single-core arrangement in which the switch interface is left unconnected. Every (source, destination) core pair has its own `DEPTH`-entry mailbox FIFO holding whole `LANES`-wide vectors. Sends and receives use the existing core-side request/acknowledge handshake. Data is carried as raw IEEE-754 bit patterns so the block is synthesizable.

## Interface
- `CORE_COUNT`, default 4: number of attached cores; must be ≥2.
- `LANES`, default 16: elements per transferred vector.
- `DATA_WIDTH`, default 32: bits per element.
- `DEPTH`, default 2: entries per mailbox FIFO; must be ≥1.
- `ADDR_SIZE`, default $clog2(CORE_COUNT): derived parameter; width of a core index.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `send_ready`  in  [CORE_COUNT]: core i requests a send.
- `send_core_idx`  in  [CORE_COUNT][ADDR_SIZE]: destination core of core i's send.
- `send_data`  in  [CORE_COUNT][LANES*DATA_WIDTH]: vector core i sends.
- `send_ok`  out  [CORE_COUNT]: one-cycle pulse; core i's send was accepted.
- `recv_request`  in  [CORE_COUNT]: core j requests a receive.
- `recv_core_idx`  in  [CORE_COUNT][ADDR_SIZE]: source core j receives from.
- `recv_ready`  out  [CORE_COUNT]: one-cycle pulse; `recv_data[j]` is valid.
- `recv_data`  out  [CORE_COUNT][LANES*DATA_WIDTH]: received vector.
- `mbox_full`  out  [CORE_COUNT][CORE_COUNT]: status; `[src][dst]` mailbox holds `DEPTH` entries.
- `mbox_empty`  out  [CORE_COUNT][CORE_COUNT]: status; `[src][dst]` mailbox holds 0 entries.

## Operation
- Storage is `CORE_COUNT*CORE_COUNT` independent FIFOs, `mbox[src][dst]`. Each has a read pointer, a write pointer (both wrap modulo `DEPTH`) and an occupancy count in 0..`DEPTH`.
- **Send accept for core i.** Occurs when `send_ready[i]` is high, `send_ok[i]` is currently low, and `mbox[i][send_core_idx[i]]` is not full. On that clock edge, `send_data[i]` is written at the write pointer, the write pointer advances, and the count increments. `send_ok[i]` is 1 for the next cycle.
- The sender holds `send_ready`, `send_core_idx` and `send_data` stable until it sees `send_ok`.
- If `send_ready` is still high in the cycle `send_ok` is high, it is ignored. The earliest next accept is in the following cycle.
- **Receive accept for core j.** Occurs when `recv_request[j]` is high, `recv_ready[j]` is currently low, and `mbox[recv_core_idx[j]][j]` is not empty. On that edge, the head entry is registered into `recv_data[j]`, the read pointer advances, and the count decrements. `recv_ready[j]` is 1 for the next cycle.
- `recv_data[j]` holds its value until the next receive accept for core j.
- **Self-send.** `send_core_idx[i] == i` is legal and uses loopback mailbox `mbox[i][i]`.
- **Ordering.** FIFO order is preserved per (src, dst) pair. No ordering guarantee exists across different pairs.
- **Index out of range** (possible only when `CORE_COUNT` is not a power of 2). The request is never accepted and no state changes; the core stalls.
- **Full/empty decisions** use the count at the start of the cycle. There is no bypass in either direction:
  - a push to a full mailbox is refused even if the same mailbox pops in that cycle;
  - a pop from an empty mailbox is refused even if the same mailbox is pushed in that cycle.
- **Simultaneous push and pop** on a non-full, non-empty mailbox: both happen and the count is unchanged.
- **Contention.** Each mailbox has exactly one writer (its src) and one reader (its dst), so no arbitration is needed.
  - Several sources may push to the same destination in one cycle, into different mailboxes.
  - Several destinations may pop from the same source in one cycle, from different mailboxes.

## Timing
- Reset values:
  - all counts and pointers 0;
  - `send_ok` 0, `recv_ready` 0, `recv_data` all-zero;
  - `mbox_empty` all 1, `mbox_full` all 0.
- Reset asserted mid-operation discards all mailbox contents. Any pulse due the next cycle is suppressed.
- Send latency: request sampled at edge t gives `send_ok` high in cycle t+1. The data is poppable by an accept sampled at edge t+1 at the earliest.
- Receive latency: request sampled at edge t gives `recv_ready` high and `recv_data` valid in cycle t+1.
- Minimum end-to-end time, send request to data at destination: 2 cycles.
- Sustained throughput per port: one transfer every 2 cycles.
- `mbox_full` and `mbox_empty` are registered and reflect the count after each edge.

## Test plan
1. **Reset state.** Hold reset 2 cycles, then release. Required: all `send_ok`, `recv_ready` and `recv_data` are 0, and all `mbox_empty` are 1.
2. **Single transfer.** Core 0 sends lane k = k+1.0 (bit pattern) to core 2. Required: `send_ok[0]` high exactly 1 cycle. Then core 2 receives from 0: `recv_ready[2]` pulses once with the same 16 lanes, and `mbox_empty[0][2]` returns to 1.
3. **Full mailbox with `DEPTH`=2.** Core 1 sends A, B, C to core 3 with no receiver. Required:
   - A and B are acked; C stalls with `send_ok[1]` low and `mbox_full[1][3]` = 1.
   - After core 3 pops once (yielding A), C is acked.
   - Subsequent pops yield B, then C.
4. **Empty and no bypass.** Core 2 requests from core 0 while the mailbox is empty, and core 0 sends in that same cycle. Required: no `recv_ready` that cycle. `recv_ready[2]` fires one cycle after the send is written, carrying core 0's data.
5. **Concurrency.** In one cycle all 4 cores send to core 0, including a loopback. Core 0 then receives from sources 3, 1, 0, 2 in that order. Required: every `send_ok` fires in the same cycle, and each received vector matches its source.
6. **Reset mid-operation.** Fill `mbox[0][1]` with 2 entries and assert reset. Required: `mbox_empty[0][1]` = 1. A subsequent receive by core 1 from core 0 stalls with no `recv_ready`.
